// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: 16-bit frames, replays tx_buf, reports rx words.
// Optional SPI_SLAVE_LOOPBACK_EN adds a loopback port (reply = last rx word).
module spi_slave_responder (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_bar,
    input  logic        din_mosi,
    output logic        dout_miso,
    input  logic [15:0] tx_data,
    input  logic        tx_load,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        frame_err
`ifdef SPI_SLAVE_LOOPBACK_EN
    ,
    input  logic        loopback
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_CS
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic        r_sclk_s1, r_sclk_s2, r_sclk_s3;
    logic        r_cs_s1, r_cs_s2, r_cs_s3;
    logic        r_mosi_s1, r_mosi_s2;
    logic [1:0]  r_init;
    logic        r_armed;

    logic [15:0] r_tx_buf;
    logic [15:0] r_tx_shift;
    logic [15:0] r_rx_shift;
    logic [15:0] r_rx_data;
    logic [4:0]  r_bit_cnt;
    logic        r_miso;
    logic        r_rx_valid;
    logic        r_frame_err;

    logic        w_sclk_rise;
    logic        w_sclk_fall;
    logic        w_cs_fall;
    logic        w_start;
    logic        w_abort;
    logic        w_shift_in;
    logic        w_shift_out;
    logic        w_last;
    logic [15:0] w_buf_src;
    logic [15:0] w_tx_src;

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_s3;
    assign w_cs_fall   = ~r_cs_s2 & r_cs_s3;

    assign w_start     = (r_state == IDLE) & w_cs_fall & r_armed;
    assign w_abort     = (r_state == SHIFT) & r_cs_s2;
    assign w_shift_in  = (r_state == SHIFT) & ~r_cs_s2 & w_sclk_rise;
    assign w_shift_out = (r_state == SHIFT) & ~r_cs_s2 & w_sclk_fall;
    assign w_last      = w_shift_in & (r_bit_cnt == 5'd15);

    assign w_buf_src   = tx_load ? tx_data : r_tx_buf;
`ifdef SPI_SLAVE_LOOPBACK_EN
    assign w_tx_src    = loopback ? r_rx_data : w_buf_src;
`else
    assign w_tx_src    = w_buf_src;
`endif

    assign dout_miso   = r_miso;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;

    // Arm only after cs_bar is seen truly high, so a low held through reset never starts a frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_s3 <= 1'b0;
            r_cs_s1   <= 1'b1;
            r_cs_s2   <= 1'b1;
            r_cs_s3   <= 1'b1;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
            r_init    <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_s3 <= r_sclk_s2;
            r_cs_s1   <= cs_bar;
            r_cs_s2   <= r_cs_s1;
            r_cs_s3   <= r_cs_s2;
            r_mosi_s1 <= din_mosi;
            r_mosi_s2 <= r_mosi_s1;
            r_init    <= {r_init[0], 1'b1};
            r_armed   <= r_armed | (r_init[1] & r_cs_s2);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_next = SHIFT;
            SHIFT: begin
                if (r_cs_s2) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = WAIT_CS;
                end
            end
            WAIT_CS: if (r_cs_s2) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tx_buf    <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_data   <= '0;
            r_bit_cnt   <= '0;
            r_miso      <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            if (tx_load) begin
                r_tx_buf <= tx_data;
            end
            if (w_start) begin
                r_tx_shift <= w_tx_src;
                r_miso     <= w_tx_src[15];
                r_bit_cnt  <= '0;
            end else if (w_abort) begin
                r_frame_err <= 1'b1;
                r_miso      <= 1'b0;
            end else if (w_shift_in) begin
                r_rx_shift <= {r_rx_shift[14:0], r_mosi_s2};
                r_bit_cnt  <= r_bit_cnt + 5'd1;
                if (w_last) begin
                    r_rx_data  <= {r_rx_shift[14:0], r_mosi_s2};
                    r_rx_valid <= 1'b1;
                    r_miso     <= 1'b0;
                end
            end else if (w_shift_out) begin
                r_tx_shift <= {r_tx_shift[14:0], 1'b0};
                r_miso     <= r_tx_shift[14];
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: vector table plus reset
// and mid-frame sequences; clk 50 MHz, sclk = clk/16.
module tb_spi_slave_responder;

    localparam time HALF = 160ns;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sclk = 1'b0;
    logic        cs_bar = 1'b1;
    logic        din_mosi = 1'b0;
    logic        dout_miso;
    logic [15:0] tx_data = '0;
    logic        tx_load = 1'b0;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
`ifdef SPI_SLAVE_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    int passed = 0;
    int total = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;

    spi_slave_responder dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .cs_bar    (cs_bar),
        .din_mosi  (din_mosi),
        .dout_miso (dout_miso),
        .tx_data   (tx_data),
        .tx_load   (tx_load),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err)
`ifdef SPI_SLAVE_LOOPBACK_EN
        ,
        .loopback  (loopback)
`endif
    );

    always #10ns clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) rv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    typedef struct {
        logic        ld;
        logic [15:0] tx;
        logic [15:0] mosi;
        int          nbits;
        logic        chk_miso;
        logic [15:0] exp_miso;
        logic [15:0] exp_rx;
        int          exp_rv;
        int          exp_fe;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic load_tx(input logic [15:0] w);
        @(negedge clk);
        tx_data = w;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic frame(input logic [15:0] w, input int nbits,
                         input logic mid_ld, input logic [15:0] mid_w,
                         output logic [15:0] miso_w);
        miso_w = '0;
        cs_bar = 1'b0;
        #(HALF);
        for (int i = 0; i < nbits; i++) begin
            din_mosi = (i < 16) ? w[15-i] : 1'b0;
            #(HALF);
            sclk = 1'b1;
            if (i < 16) miso_w = {miso_w[14:0], dout_miso};
            #(HALF);
            sclk = 1'b0;
            if (mid_ld && i == 4) load_tx(mid_w);
        end
        #(HALF);
        cs_bar = 1'b1;
        #(4*HALF);
    endtask

    initial begin
        logic [15:0] mw;
        int rv0, fe0;

        vecs[0] = '{1'b1, 16'hF1F1, 16'h0003, 16, 1'b1, 16'hF1F1,
                    16'h0003, 1, 0};
        for (int k = 0; k < 16; k++)
            vecs[1+k] = '{1'b0, 16'h0000, 16'(k), 16, 1'b1, 16'hF1F1,
                          16'(k), 1, 0};
        vecs[17] = '{1'b0, 16'h0000, 16'hFFFF, 7, 1'b0, 16'h0000,
                     16'h000F, 0, 1};
        vecs[18] = '{1'b0, 16'h0000, 16'hBEEF, 20, 1'b1, 16'hF1F1,
                     16'hBEEF, 1, 0};
        vecs[19] = '{1'b1, 16'h1357, 16'h2468, 16, 1'b1, 16'h1357,
                     16'h2468, 1, 0};

        #105ns;
        chk("rst_miso", 32'(dout_miso), 32'd0);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_rx", 32'(rx_data), 32'd0);
        reset = 1'b1;
        #200ns;

        for (int v = 0; v < 20; v++) begin
            if (vecs[v].ld) load_tx(vecs[v].tx);
            rv0 = rv_cnt;
            fe0 = fe_cnt;
            frame(vecs[v].mosi, vecs[v].nbits, 1'b0, 16'h0, mw);
            if (vecs[v].chk_miso)
                chk($sformatf("v%0d_miso", v), 32'(mw), 32'(vecs[v].exp_miso));
            chk($sformatf("v%0d_rx", v), 32'(rx_data), 32'(vecs[v].exp_rx));
            chk($sformatf("v%0d_rv", v), 32'(rv_cnt - rv0), 32'(vecs[v].exp_rv));
            chk($sformatf("v%0d_fe", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
            chk($sformatf("v%0d_idle_miso", v), 32'(dout_miso), 32'd0);
        end

        // tx_load mid-frame must only affect the following frame
        frame(16'h0F0F, 16, 1'b1, 16'hCAFE, mw);
        chk("midld_miso", 32'(mw), 32'h1357);
        chk("midld_rx", 32'(rx_data), 32'h0F0F);
        frame(16'h0000, 16, 1'b0, 16'h0, mw);
        chk("midld_next_miso", 32'(mw), 32'hCAFE);

        // reset after 5 bits with cs_bar still low
        cs_bar = 1'b0;
        #(HALF);
        for (int i = 0; i < 5; i++) begin
            #(HALF); sclk = 1'b1;
            #(HALF); sclk = 1'b0;
        end
        fe0 = fe_cnt;
        rv0 = rv_cnt;
        #(HALF/2);
        reset = 1'b0;
        #1ns;
        chk("mrst_miso", 32'(dout_miso), 32'd0);
        chk("mrst_valid", 32'(rx_valid), 32'd0);
        chk("mrst_err", 32'(frame_err), 32'd0);
        chk("mrst_rx", 32'(rx_data), 32'd0);
        #100ns;
        reset = 1'b1;
        #200ns;
        // cs_bar low through release: clocks must be ignored
        for (int i = 0; i < 16; i++) begin
            din_mosi = 1'b1;
            #(HALF); sclk = 1'b1;
            #(HALF); sclk = 1'b0;
        end
        #(HALF);
        cs_bar = 1'b1;
        #(4*HALF);
        chk("rel_low_rv", 32'(rv_cnt - rv0), 32'd0);
        chk("rel_low_fe", 32'(fe_cnt - fe0), 32'd0);
        chk("rel_low_rx", 32'(rx_data), 32'd0);
        rv0 = rv_cnt;
        frame(16'h1234, 16, 1'b0, 16'h0, mw);
        chk("post_rst_rx", 32'(rx_data), 32'h1234);
        chk("post_rst_rv", 32'(rv_cnt - rv0), 32'd1);
        chk("post_rst_miso", 32'(mw), 32'h0000);
        chk("post_rst_fe", 32'(fe_cnt - fe0), 32'd0);

`ifdef SPI_SLAVE_LOOPBACK_EN
        load_tx(16'h5555);
        frame(16'hA5C3, 16, 1'b0, 16'h0, mw);
        chk("lb_rx", 32'(rx_data), 32'hA5C3);
        loopback = 1'b1;
        frame(16'h0000, 16, 1'b0, 16'h0, mw);
        loopback = 1'b0;
        chk("lb_miso", 32'(mw), 32'hA5C3);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
